// File: rtl/stopwatch_disp_pkg.sv
// Purpose: shared constants for the stopwatch MM.SS display slice.
// Latency: n/a (constants only).
// Backpressure: none.
// Contents: active-low segment patterns {g,f,e,d,c,b,a}, digit indices, decoder codes.
package stopwatch_disp_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Scan order: digit 0 is the rightmost (seconds units).
  localparam logic [1:0] DIG_SEC_U = 2'd0;
  localparam logic [1:0] DIG_SEC_T = 2'd1;
  localparam logic [1:0] DIG_MIN_U = 2'd2;
  localparam logic [1:0] DIG_MIN_T = 2'd3;

  // Decoder codes beyond the decimal digits.
  localparam logic [3:0] CODE_DASH  = 4'd10;
  localparam logic [3:0] CODE_BLANK = 4'd15;

  // Highest value a min/sec field may legally carry.
  localparam logic [5:0] FIELD_MAX = 6'd59;

endpackage

// File: rtl/stopwatch_display_seg7_decode.sv
// Purpose: 4-bit digit code to active-low 7-segment pattern.
// Latency: combinational.
// Backpressure: none.
// Ports: code (0-9 digit, 10 dash, 15 blank; others blank) -> seg {g,f,e,d,c,b,a}.
module seg7_decode
  import stopwatch_disp_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      4'd0:      seg = SEG_0;
      4'd1:      seg = SEG_1;
      4'd2:      seg = SEG_2;
      4'd3:      seg = SEG_3;
      4'd4:      seg = SEG_4;
      4'd5:      seg = SEG_5;
      4'd6:      seg = SEG_6;
      4'd7:      seg = SEG_7;
      4'd8:      seg = SEG_8;
      4'd9:      seg = SEG_9;
      CODE_DASH: seg = SEG_DASH;
      default:   seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/stopwatch_display.sv
// Purpose: multiplexed 4-digit common-anode MM.SS display driver with per-frame input snapshot.
// Latency: outputs registered one cycle after scan state; input-to-display worst case 4*CLK_DIV+1 cycles.
// Backpressure: none; inputs are sampled only at the frame boundary and ignored otherwise.
// Ports: clk, reset (sync, active-high), sec/min (binary 0-59), running -> an, seg, dp (all active-low).
module stopwatch_display
  import stopwatch_disp_pkg::*;
#(
  parameter int CLK_DIV     = 100000,
  parameter int BLINK_SCANS = 64,
  parameter int LZ_BLANK    = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  input  logic       running,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int FW = $clog2(BLINK_SCANS + 1);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic          tick;
  logic          frame_end;

  logic [5:0]    shadow_sec;
  logic [5:0]    shadow_min;
  logic          shadow_running;

  logic          blink_dark;   // 0 = lit phase
  logic [FW-1:0] frame_cnt;

  logic [3:0]    code;
  logic [6:0]    seg_nxt;
  logic [3:0]    an_nxt;
  logic          dp_nxt;

  assign tick      = (cnt == CW'(CLK_DIV - 1));
  assign frame_end = tick && (idx == DIG_MIN_T);

  // Digit dwell divider and scan index.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      idx <= DIG_SEC_U;
    end else if (tick) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Snapshot at the frame boundary so one frame never mixes two input values.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_sec     <= '0;
      shadow_min     <= '0;
      shadow_running <= 1'b0;
    end else if (frame_end) begin
      shadow_sec     <= sec;
      shadow_min     <= min;
      shadow_running <= running;
    end
  end

  // Stopped-state blink: while running the phase is held lit and the frame
  // count is kept clear, so blinking always restarts from a lit phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_dark <= 1'b0;
      frame_cnt  <= '0;
    end else if (shadow_running) begin
      blink_dark <= 1'b0;
      frame_cnt  <= '0;
    end else if (frame_end) begin
      if (frame_cnt == FW'(BLINK_SCANS - 1)) begin
        frame_cnt  <= '0;
        blink_dark <= ~blink_dark;
      end else begin
        frame_cnt <= frame_cnt + FW'(1);
      end
    end
  end

  // Binary-to-digit split; a field outside 0-59 shows dashes on both its digits.
  always_comb begin
    code = CODE_BLANK;
    case (idx)
      DIG_SEC_U: code = (shadow_sec > FIELD_MAX) ? CODE_DASH : 4'(shadow_sec % 6'd10);
      DIG_SEC_T: code = (shadow_sec > FIELD_MAX) ? CODE_DASH : 4'(shadow_sec / 6'd10);
      DIG_MIN_U: code = (shadow_min > FIELD_MAX) ? CODE_DASH : 4'(shadow_min % 6'd10);
      default: begin
        code = (shadow_min > FIELD_MAX) ? CODE_DASH : 4'(shadow_min / 6'd10);
        if ((LZ_BLANK != 0) && (code == 4'd0)) code = CODE_BLANK;
      end
    endcase
  end

  seg7_decode u_decode (
    .code (code),
    .seg  (seg_nxt)
  );

  always_comb begin
    an_nxt = ~(4'b0001 << idx);
    dp_nxt = 1'b1;
    if (idx == DIG_MIN_U) dp_nxt = shadow_running ? 1'b0 : blink_dark;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= 4'b1111;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
      dp  <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_stopwatch_display.sv
// Bench for stopwatch_display: two instances (leading-zero blanking off/on) share stimulus.
// Stimulus pushes one expected output per clock edge from a frame-position model;
// a separate monitor pops and compares each cycle.
module tb_stopwatch_display;

  localparam int CLK_DIV = 4;
  localparam int BLINK   = 2;
  localparam int NCYC    = 3000;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] sec, min;
  logic       running;
  logic [3:0] an0, an1;
  logic [6:0] seg0, seg1;
  logic       dp0, dp1;

  always #5 clk = ~clk;

  stopwatch_display #(.CLK_DIV(CLK_DIV), .BLINK_SCANS(BLINK), .LZ_BLANK(0)) u_dut0 (
    .clk(clk), .reset(reset), .sec(sec), .min(min), .running(running),
    .an(an0), .seg(seg0), .dp(dp0)
  );

  stopwatch_display #(.CLK_DIV(CLK_DIV), .BLINK_SCANS(BLINK), .LZ_BLANK(1)) u_dut1 (
    .clk(clk), .reset(reset), .sec(sec), .min(min), .running(running),
    .an(an1), .seg(seg1), .dp(dp1)
  );

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg0;   // expected with no blanking
    logic [6:0] seg1;   // expected with leading-zero blanking
    logic       dp;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  logic done  = 1'b0;

  // Model state: position within the 16-cycle frame, captured values, idle frames.
  int pos, s_sec, s_min, idle;
  logic s_run;
  logic do_rst, did_mid;

  // Digit glyphs; -1 = dash, -2 = blank.
  function automatic logic [6:0] glyph(int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      -1: return 7'b0111111;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic exp_t model_out(int p, int cyc);
    exp_t e;
    int dig, v, d;
    dig = p / CLK_DIV;
    v   = (dig < 2) ? s_sec : s_min;
    if (v > 59) d = -1;
    else        d = (dig % 2 == 0) ? (v % 10) : (v / 10);
    e.an      = 4'hF;
    e.an[dig] = 1'b0;
    e.seg0    = glyph(d);
    e.seg1    = (dig == 3 && d == 0) ? glyph(-2) : glyph(d);
    if (dig == 2) e.dp = s_run ? 1'b0 : (((idle / BLINK) % 2) == 1);
    else          e.dp = 1'b1;
    e.cyc = cyc;
    return e;
  endfunction

  // Stimulus: one iteration per clock edge, driven at the preceding negedge.
  initial begin
    exp_t er;
    reset = 1'b1; sec = '0; min = '0; running = 1'b0;
    pos = 0; s_sec = 0; s_min = 0; s_run = 1'b0; idle = 0; did_mid = 1'b0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      do_rst = (cyc < 3);
      // Mid-frame reset with the scan at digit 2, second dwell cycle.
      if (cyc >= 1500 && !did_mid && pos == 2 * CLK_DIV + 1) begin
        do_rst  = 1'b1;
        did_mid = 1'b1;
      end
      if (do_rst) begin
        reset = 1'b1;
        er.an = 4'hF; er.seg0 = 7'h7F; er.seg1 = 7'h7F; er.dp = 1'b1; er.cyc = cyc;
        q.push_back(er);
        pos = 0; s_sec = 0; s_min = 0; s_run = 1'b0; idle = 0;
      end else begin
        reset = 1'b0;
        q.push_back(model_out(pos, cyc));
        if (cyc == 3) begin
          min = 6'd12; sec = 6'd59; running = 1'b0;
        end else if (cyc == 24) begin
          sec = 6'd7;                         // changes while digit 1 is shown
        end else if (cyc == 51) begin
          sec = 6'd61; min = 6'd3; running = 1'b1;
        end else if (cyc == 99) begin
          running = 1'b0;
        end else if (cyc >= 200) begin
          if ($urandom_range(5) == 0) sec = 6'($urandom_range(63));
          if ($urandom_range(5) == 0)
            min = ($urandom_range(1) == 0) ? 6'($urandom_range(9)) : 6'($urandom_range(63));
          if ($urandom_range(99) == 0) running = ~running;
        end
        if (pos == 4 * CLK_DIV - 1) begin
          if (s_run) idle = 0;
          else       idle = idle + 1;
          s_sec = int'(sec); s_min = int'(min); s_run = running;
          pos = 0;
        end else begin
          pos = pos + 1;
        end
      end
      @(negedge clk);
    end
    done = 1'b1;
  end

  // Monitor: compares every cycle, 1 time unit after the active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (done) begin
        tests++;
        if (q.size() != 0) begin
          fails++;
          $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
      end else if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL underflow: DUT output with no expectation queued");
      end else begin
        e = q.pop_front();
        tests++;
        if (an0 !== e.an || an1 !== e.an || seg0 !== e.seg0 || seg1 !== e.seg1 ||
            dp0 !== e.dp || dp1 !== e.dp) begin
          fails++;
          $display("FAIL out cyc=%0d got an=%b/%b seg=%b/%b dp=%b/%b want an=%b seg=%b/%b dp=%b",
                   e.cyc, an0, an1, seg0, seg1, dp0, dp1, e.an, e.seg0, e.seg1, e.dp);
        end
      end
    end
  end

  // Bound on total runtime regardless of stimulus progress.
  initial begin
    #((NCYC + 100) * 10);
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
